jtcps1_star_ctrl: RTL
=====================

# jtcps1_star_ctrl

Register and sequencing controller for the CPS1 two-layer star field generator. It holds CPU-written star scroll and control registers in a shadow bank and commits them to the star generator only at vertical blank start, so scroll values never change mid-frame. It also runs a frame-based blink sequencer that produces per-layer palette phase counters. It sits between the CPU register decoder and the star generator plus colour mixer.

## Interface
Parameters:
- PHASE_W, 3, width of each blink phase counter.

Ports:
- rst  input  1  reset; asynchronous, active-high.
- clk  input  1  system clock; all state changes on its rising edge.
- VB  input  1  vertical blank from the video timing block.
- regs_cs  input  1  register access select; high for one clk cycle per access.
- cpu_wrn  input  1  low = write, high = read (valid with regs_cs).
- cpu_addr  input  3  register index: 0 hpos0, 1 vpos0, 2 hpos1, 3 vpos1, 4 ctrl; 5-7 unmapped.
- cpu_dsn  input  2  active-low byte enables; [1] for bits 15:8, [0] for bits 7:0.
- cpu_dout  input  16  CPU write data.
- cpu_din  output  16  read data; combinational shadow value at cpu_addr, 0 for unmapped addresses.
- hpos0, vpos0, hpos1, vpos1  output  16 each  committed scroll values to the star generator.
- star_en  output  2  committed layer enables (ctrl bits 1:0).
- phase0, phase1  output  PHASE_W each  blink palette phase per layer.
- pending  output  1  shadow bank holds uncommitted writes.

## Operation
- Shadow bank: five 16-bit registers. A write (regs_cs=1, cpu_wrn=0, mapped address) updates only the bytes whose cpu_dsn bit is 0. A write with cpu_dsn=2'b11, or to addresses 5-7, changes nothing and does not set pending.
- ctrl layout: [1:0] layer enables; [7:4] blink period P (frames-1); [8] freeze (hold phases); other bits are storage only.
- VB rise detection: vb_l holds VB from the previous cycle. commit = VB & ~vb_l.
- On commit, all outputs (hpos/vpos, star_en, and the internal period and freeze copies) load the shadow bank contents as they stood before that edge.
- Write on the commit cycle: the shadow takes the new data, the outputs take the pre-write values, and pending stays 1.
- pending: set by any effective write; cleared on commit unless an effective write occurs in the same cycle.
- Blink sequencer, advanced only on commit cycles and using the committed P and freeze values as they were before the edge:
  - Frame counter fcnt is 4 bits.
  - If freeze=1, fcnt and both phases hold.
  - Else if fcnt==P: fcnt<=0, phase0<=phase0+1, phase1<=phase1-1. Both wrap modulo 2^PHASE_W.
  - Else fcnt<=fcnt+1.
  - P=0 advances the phases on every frame.
- A newly committed P takes effect at the next commit. If fcnt>P after a change, fcnt counts up and wraps at 15->0 before it can match P.
- Reads have no side effects.

## Timing
- Reset, asynchronous: all shadow registers, outputs, fcnt and pending go to 0. vb_l resets to 1, so VB already high at reset release produces no commit.
- Write latency: the shadow value is updated at the clk edge where regs_cs is sampled. cpu_din reflects it in the following cycle.
- Commit latency: outputs change at the first clk edge with VB=1 and vb_l=0, which is one edge after VB rises. They are then stable until the next VB rise.
- Phase update happens on the same edge as the commit.
- VB held high for many cycles produces exactly one commit. VB pulses of a single cycle each produce a commit.
- Reset asserted mid-frame discards pending writes. Outputs read 0 immediately, without waiting for a clock edge.

## Test plan
- Reset, then write hpos0=16'h0123 with VB low -> hpos0 output stays 0 and pending=1. Raise VB -> one edge later hpos0=16'h0123 and pending=0.
- Byte write to vpos1: first 16'hAABB with dsn=00, then 16'h11CC with dsn=10 -> shadow reads 16'hAACC. A write with dsn=11 leaves the value unchanged and pending unchanged.
- Write hpos1=16'h0055 on the exact commit edge, with the shadow holding 16'h0044 -> output 16'h0044, pending=1. The next VB rise outputs 16'h0055.
- ctrl=16'h0023 committed (en=2'b11, P=2). Run 9 frames -> phases advance on frames 3, 6 and 9 after the commit: phase0=3, phase1=5 (3-bit).
- Set freeze by writing ctrl=16'h0103 and run 4 frames -> phases constant after the commit frame. Clear freeze -> counting resumes from the held fcnt.
- Assert rst with VB high mid-frame and pending=1 -> all outputs 0 asynchronously. Release rst with VB still high -> no commit until VB falls and rises again.

Source files
------------

// File: rtl/jtcps1_star_ctrl_if.sv
// CPU register bus between the CPS1 register decoder and the star controller.
// The CPU side drives the access strobes and data; the controller returns read data.
interface jtcps1_star_ctrl_if;
  logic        regs_cs;
  logic        cpu_wrn;
  logic [2:0]  cpu_addr;
  logic [1:0]  cpu_dsn;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;

  modport master (
    output regs_cs, cpu_wrn, cpu_addr, cpu_dsn, cpu_dout,
    input  cpu_din
  );

  modport slave (
    input  regs_cs, cpu_wrn, cpu_addr, cpu_dsn, cpu_dout,
    output cpu_din
  );
endinterface

// File: rtl/jtcps1_star_ctrl.sv
// CPS1 star field register controller: shadow bank committed at VB rise,
// plus a frame-based blink sequencer producing per-layer palette phases.
module jtcps1_star_ctrl #(
  parameter int unsigned PHASE_W = 3
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               VB,
  jtcps1_star_ctrl_if.slave  bus,
  output logic [15:0]        hpos0,
  output logic [15:0]        vpos0,
  output logic [15:0]        hpos1,
  output logic [15:0]        vpos1,
  output logic [1:0]         star_en,
  output logic [PHASE_W-1:0] phase0,
  output logic [PHASE_W-1:0] phase1,
  output logic               pending
);

  localparam int unsigned NREG   = 5;
  localparam int unsigned FCNT_W = 4;
  localparam logic [2:0]  A_HPOS0 = 3'd0;
  localparam logic [2:0]  A_VPOS0 = 3'd1;
  localparam logic [2:0]  A_HPOS1 = 3'd2;
  localparam logic [2:0]  A_VPOS1 = 3'd3;
  localparam logic [2:0]  A_CTRL  = 3'd4;

  logic [15:0]       r_shadow [NREG];
  logic              r_vb_l;
  logic [3:0]        r_period;
  logic              r_freeze;
  logic [FCNT_W-1:0] r_fcnt;

  logic w_mapped;
  logic w_wr;
  logic w_commit;

  assign w_mapped = bus.cpu_addr < 3'(NREG);
  assign w_wr     = bus.regs_cs & ~bus.cpu_wrn & w_mapped & (bus.cpu_dsn != 2'b11);
  assign w_commit = VB & ~r_vb_l;

  // Shadow bank: byte-lane writes from the CPU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_shadow[i] <= '0;
    end else if (w_wr) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (bus.cpu_addr == 3'(i)) begin
          if (!bus.cpu_dsn[1]) r_shadow[i][15:8] <= bus.cpu_dout[15:8];
          if (!bus.cpu_dsn[0]) r_shadow[i][7:0]  <= bus.cpu_dout[7:0];
        end
      end
    end
  end

  always_comb begin
    bus.cpu_din = '0;
    case (bus.cpu_addr)
      A_HPOS0: bus.cpu_din = r_shadow[0];
      A_VPOS0: bus.cpu_din = r_shadow[1];
      A_HPOS1: bus.cpu_din = r_shadow[2];
      A_VPOS1: bus.cpu_din = r_shadow[3];
      A_CTRL:  bus.cpu_din = r_shadow[4];
      default: bus.cpu_din = '0;
    endcase
  end

  // vb_l resets high so a VB already asserted at reset release is not a rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vb_l <= 1'b1;
    else     r_vb_l <= VB;
  end

  // Commit: outputs take the shadow values from before this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos0    <= '0;
      vpos0    <= '0;
      hpos1    <= '0;
      vpos1    <= '0;
      star_en  <= '0;
      r_period <= '0;
      r_freeze <= 1'b0;
    end else if (w_commit) begin
      hpos0    <= r_shadow[0];
      vpos0    <= r_shadow[1];
      hpos1    <= r_shadow[2];
      vpos1    <= r_shadow[3];
      star_en  <= r_shadow[4][1:0];
      r_period <= r_shadow[4][7:4];
      r_freeze <= r_shadow[4][8];
    end
  end

  // A write on the commit edge keeps the bank dirty
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pending <= 1'b0;
    else if (w_wr)     pending <= 1'b1;
    else if (w_commit) pending <= 1'b0;
  end

  // Blink sequencer uses the period/freeze committed before this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      phase0 <= '0;
      phase1 <= '0;
    end else if (w_commit && !r_freeze) begin
      if (r_fcnt == r_period) begin
        r_fcnt <= '0;
        phase0 <= phase0 + PHASE_W'(1);
        phase1 <= phase1 - PHASE_W'(1);
      end else begin
        r_fcnt <= r_fcnt + FCNT_W'(1);
      end
    end
  end

endmodule
